// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the register file and its scoreboard.
//   REG_ADDR_W    default register index width
//   REG_DATA_W    default register width
//   NUM_ARCH_REGS default architectural register count
//   ZERO_REG_IDX  index of the hardwired-zero register
package cpu_pkg;
    localparam int REG_ADDR_W    = 5;
    localparam int REG_DATA_W    = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ZERO_REG_IDX  = 0;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: write ports, read ports, issue and flush.
//   master: drives wr_*, rd_addr, iss_*, flush; samples rd_data/rd_busy
//   slave : the register file
// Port p of a packed field sits at [p][...], i.e. flat bits [p*W +: W].
interface regfile_mp_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic                          iss_en;
    logic [ADDR_W-1:0]             iss_addr;
    logic                          flush;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on
// writeback, all cleared by flush. Per-entry priority at posedge:
// flush > issue > writeback > hold.
//   clk, rst_n          clock, async active-low reset
//   iss_en, iss_addr    mark destination busy
//   flush               clear every busy bit
//   wr_en, wr_addr      writeback ports (clear)
//   rd_addr -> rd_busy  combinational lookup of pre-edge state
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          iss_en,
    input  logic [ADDR_W-1:0]             iss_addr,
    input  logic                          flush,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]             rd_busy
);
    logic [NUM_REGS-1:0] busy, set, clr, busy_nxt;

    always_comb begin
        set = '0;
        clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set[i] = iss_en && (iss_addr == ADDR_W'(i));
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p] && (wr_addr[p] == ADDR_W'(i))) clr[i] = 1'b1;
        end
        // Issue beats same-cycle writeback: the new producer owns the reg.
        busy_nxt = flush ? '0 : (set | (busy & ~clr));
        if (ZERO_REG != 0) busy_nxt[ZERO_REG_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Out-of-range indices match no entry and so read as not busy.
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++)
            for (int i = 0; i < NUM_REGS; i++)
                if (rd_addr[r] == ADDR_W'(i)) rd_busy[r] = busy[i];
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard.
//   clk, rst_n  clock, async active-low reset (clears data and busy)
//   bus         regfile_mp_if.slave: NUM_WR write ports (highest port wins
//               on a shared index), NUM_RD combinational read ports with
//               busy lookup, issue and flush for the scoreboard.
// Out-of-range indices: writes dropped, reads return 0 / not busy.
// ZERO_REG=1 hardwires index 0 to zero and never busy.
// Build option REGFILE_BYPASS_EN: reads forward same-cycle write data and
// report not-busy (unless the same register is issued this cycle).
// Without it reads see pre-edge contents and busy.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [NUM_RD-1:0] sb_busy;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_REG_IDX));
    endfunction

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .flush    (bus.flush),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (sb_busy)
    );

    // Ports scanned in ascending order so the last NBA (highest port) wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int p = 0; p < NUM_WR; p++)
                    if (bus.wr_en[p] && (bus.wr_addr[p] == ADDR_W'(i)) &&
                        !((ZERO_REG != 0) && (i == ZERO_REG_IDX)))
                        mem[i] <= bus.wr_data[p];
        end
    end

    // mem[0] is never written when hardwired, so it reads 0 without a mask.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (bus.rd_addr[r] == ADDR_W'(i)) bus.rd_data[r] = mem[i];
            bus.rd_busy[r] = sb_busy[r];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++)
                if (bus.wr_en[p] && (bus.wr_addr[p] == bus.rd_addr[r]) &&
                    in_range(bus.wr_addr[p]) && !is_zero(bus.wr_addr[p])) begin
                    bus.rd_data[r] = bus.wr_data[p];
                    bus.rd_busy[r] = bus.iss_en && (bus.iss_addr == bus.rd_addr[r]);
                end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Range/zero helpers only feed the forwarding path.
    logic unused_helpers;
    assign unused_helpers = in_range('0) ^ is_zero('0);
`endif
endmodule
